// File: rtl/conv_pkg.sv
// Constants shared by the line-window front end and the 5x5 convolution block.
package conv_pkg;

  localparam int COLORDEPTH  = 8;
  localparam int SCREENWIDTH = 1600;
  localparam int M_DEPTH     = 5;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int COL_W = addr_width(SCREENWIDTH);

endpackage

// File: rtl/lb_ram.sv
// One video line of storage: single-port, read-before-write, registered read.
// old_data is the pre-write content at addr, cascaded into the next line buffer.
module lb_ram
  import conv_pkg::*;
#(
  parameter int DEPTH = SCREENWIDTH,
  parameter int WIDTH = COLORDEPTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] old_data,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign old_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/conv_line_window.sv
// Five-row vertical pixel window over the live video stream, one cycle of latency.
// Define CONV_LINE_WINDOW_REPLICATE_EN to replicate the top valid row instead of zero-filling.
module conv_line_window
  import conv_pkg::*;
#(
  parameter int COLORDEPTH  = conv_pkg::COLORDEPTH,
  parameter int SCREENWIDTH = conv_pkg::SCREENWIDTH,
  parameter int M_DEPTH     = conv_pkg::M_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] pix_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [COLORDEPTH-1:0] vect_o_0,
  output logic [COLORDEPTH-1:0] vect_o_1,
  output logic [COLORDEPTH-1:0] vect_o_2,
  output logic [COLORDEPTH-1:0] vect_o_3,
  output logic [COLORDEPTH-1:0] vect_o_4,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o,
  output logic                  ovf_o
);

  localparam int                COL_W    = addr_width(SCREENWIDTH);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(SCREENWIDTH - 1);
  localparam int                ROW_W    = addr_width(M_DEPTH);
  localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(M_DEPTH - 1);

  logic                  acc;
  logic                  we;
  logic                  line_end_evt;
  logic [COL_W-1:0]      col;
  logic                  line_open;
  logic                  wrapped;
  logic [ROW_W-1:0]      row_cnt;
  logic [ROW_W-1:0]      row_o;
  logic [COLORDEPTH-1:0] pix_q;
  logic [COLORDEPTH-1:0] tap [M_DEPTH];
  logic [COLORDEPTH-1:0] rd  [M_DEPTH];
  logic [COLORDEPTH-1:0] win [M_DEPTH];

  // A dv_i gap only ends the line once hs_i has toggled; otherwise it is a stall.
  assign acc          = dv_i & ~vs_i;
  assign we           = acc & ~rst;
  assign line_end_evt = line_open & ~dv_i & ~vs_i & (hs_i != hs_o);

  assign tap[0] = pix_i;
  assign rd[0]  = pix_q;

  for (genvar k = 1; k < M_DEPTH; k++) begin : g_line
    lb_ram #(
      .DEPTH (SCREENWIDTH),
      .WIDTH (COLORDEPTH),
      .AW    (COL_W)
    ) u_ram (
      .clk      (clk),
      .we       (we),
      .addr     (col),
      .wdata    (tap[k-1]),
      .old_data (tap[k]),
      .rdata    (rd[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      line_open  <= 1'b0;
      wrapped    <= 1'b0;
      row_cnt    <= '0;
      row_o      <= '0;
      pix_q      <= '0;
      dv_o       <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
      line_end_o <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      dv_o       <= acc;
      hs_o       <= hs_i;
      vs_o       <= vs_i;
      pix_q      <= acc ? pix_i : '0;
      row_o      <= row_cnt;
      line_end_o <= line_end_evt;
      if (vs_i) begin
        col       <= '0;
        line_open <= 1'b0;
        wrapped   <= 1'b0;
        row_cnt   <= '0;
        ovf_o     <= 1'b0;
      end else if (acc) begin
        line_open <= 1'b1;
        if (wrapped) ovf_o <= 1'b1;
        if (col == COL_LAST) begin
          col     <= '0;
          wrapped <= 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else if (line_end_evt) begin
        col       <= '0;
        line_open <= 1'b0;
        wrapped   <= 1'b0;
        if (row_cnt < ROW_MAX) row_cnt <= row_cnt + 1'b1;
      end
    end
  end

  // Rows above the top of the frame hold stale RAM data, so they are masked.
  always_comb begin
    for (int k = 0; k < M_DEPTH; k++) begin
      win[k] = '0;
      if (dv_o) begin
        if (ROW_W'(k) <= row_o) begin
          win[k] = rd[k];
        end else begin
`ifdef CONV_LINE_WINDOW_REPLICATE_EN
          win[k] = rd[row_o];
`else
          win[k] = '0;
`endif
        end
      end
    end
  end

  assign vect_o_0 = win[0];
  assign vect_o_1 = win[1];
  assign vect_o_2 = win[2];
  assign vect_o_3 = win[3];
  assign vect_o_4 = win[4];

endmodule

// File: tb/tb_conv_line_window.sv
// Directed vector bench for conv_line_window with an 8-pixel line (pixel = 16*row+col).
module tb_conv_line_window;

`ifdef CONV_LINE_WINDOW_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_i = '0;
  logic       dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [7:0] vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4;
  logic       dv_o, hs_o, vs_o, line_end_o, ovf_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  pix;
    logic        dv, hs, vs, chk;
    logic [39:0] ev;
    logic        edv, ele, eovf;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  conv_line_window #(.COLORDEPTH(8), .SCREENWIDTH(8), .M_DEPTH(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_i      (pix_i),
    .dv_i       (dv_i),
    .hs_i       (hs_i),
    .vs_i       (vs_i),
    .vect_o_0   (vect_o_0),
    .vect_o_1   (vect_o_1),
    .vect_o_2   (vect_o_2),
    .vect_o_3   (vect_o_3),
    .vect_o_4   (vect_o_4),
    .dv_o       (dv_o),
    .hs_o       (hs_o),
    .vs_o       (vs_o),
    .line_end_o (line_end_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fill(input logic [7:0] v);
    return REP ? v : 8'h00;
  endfunction

  task automatic pv(input logic r, input logic [7:0] p, input logic d, input logic h, input logic v);
    vec_t x;
    x.rst = r; x.pix = p; x.dv = d; x.hs = h; x.vs = v; x.chk = 1'b0;
    x.ev = '0; x.edv = 1'b0; x.ele = 1'b0; x.eovf = 1'b0; x.tag = "";
    vecs.push_back(x);
  endtask

  task automatic cv(input logic r, input logic [7:0] p, input logic d, input logic h, input logic v,
                    input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                    input logic [7:0] e3, input logic [7:0] e4,
                    input logic edv, input logic ele, input logic eovf, input string t);
    vec_t x;
    x.rst = r; x.pix = p; x.dv = d; x.hs = h; x.vs = v; x.chk = 1'b1;
    x.ev = {e0, e1, e2, e3, e4}; x.edv = edv; x.ele = ele; x.eovf = eovf; x.tag = t;
    vecs.push_back(x);
  endtask

  // Line-end blanking: hs toggles on the first idle cycle, then settles back.
  task automatic blanks(input logic chk, input logic eovf, input string t);
    if (chk) cv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, eovf, t);
    else     pv(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst; pix_i = v.pix; dv_i = v.dv; hs_i = v.hs; vs_i = v.vs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [44:0] obs, expv;
    obs  = {vect_o_0, vect_o_1, vect_o_2, vect_o_3, vect_o_4, dv_o, line_end_o, ovf_o, hs_o, vs_o};
    expv = {v.ev, v.edv, v.ele, v.eovf, v.hs, v.vs};
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h, want %h (v0..v4,dv,le,ovf,hs,vs)", v.tag, obs, expv);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pv(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    pv(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    pv(1'b0, 8'h31, 1'b1, 1'b0, 1'b0);
    pv(1'b0, 8'h32, 1'b1, 1'b0, 1'b0);
    cv(1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h33, fill(8'h33), fill(8'h33), fill(8'h33), fill(8'h33),
       1'b1, 1'b0, 1'b0, "pre_reset");
    for (int i = 0; i < 3; i++)
      cv(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_hold");
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 8; c++)
      if (c == 5) cv(1'b0, 8'h05, 1'b1, 1'b0, 1'b0, 8'h05, fill(8'h05), fill(8'h05), fill(8'h05), fill(8'h05),
                     1'b1, 1'b0, 1'b0, "line0_top");
      else pv(1'b0, 8'(c), 1'b1, 1'b0, 1'b0);
    blanks(1'b1, 1'b0, "line0_end");

    for (int c = 0; c < 8; c++)
      if (c == 2) cv(1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 8'h12, 8'h02, fill(8'h02), fill(8'h02), fill(8'h02),
                     1'b1, 1'b0, 1'b0, "line1_border");
      else pv(1'b0, 8'(16 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b0, 1'b0, "");

    for (int c = 0; c < 8; c++)
      if (c == 6) cv(1'b0, 8'h26, 1'b1, 1'b0, 1'b0, 8'h26, 8'h16, 8'h06, fill(8'h06), fill(8'h06),
                     1'b1, 1'b0, 1'b0, "line2_border");
      else pv(1'b0, 8'(32 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b0, 1'b0, "");

    for (int c = 0; c < 8; c++) pv(1'b0, 8'(48 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b0, 1'b0, "");

    for (int c = 0; c < 8; c++)
      if (c == 3) cv(1'b0, 8'h43, 1'b1, 1'b0, 1'b0, 8'h43, 8'h33, 8'h23, 8'h13, 8'h03,
                     1'b1, 1'b0, 1'b0, "line4_window");
      else pv(1'b0, 8'(64 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b1, 1'b0, "line4_end");

    for (int c = 0; c < 3; c++) pv(1'b0, 8'(80 + c), 1'b1, 1'b0, 1'b0);
    cv(1'b0, 8'h53, 1'b1, 1'b0, 1'b0, 8'h53, 8'h43, 8'h33, 8'h23, 8'h13, 1'b1, 1'b0, 1'b0, "row_saturate");
    for (int i = 0; i < 3; i++)
      cv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "stall");
    cv(1'b0, 8'h54, 1'b1, 1'b0, 1'b0, 8'h54, 8'h44, 8'h34, 8'h24, 8'h14, 1'b1, 1'b0, 1'b0, "stall_resume");
    for (int c = 5; c < 8; c++) pv(1'b0, 8'(80 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b1, 1'b0, "line5_end");

    for (int c = 0; c < 7; c++) pv(1'b0, 8'(96 + c), 1'b1, 1'b0, 1'b0);
    cv(1'b0, 8'h67, 1'b1, 1'b0, 1'b0, 8'h67, 8'h57, 8'h47, 8'h37, 8'h27, 1'b1, 1'b0, 1'b0, "ovf_not_yet");
    cv(1'b0, 8'h68, 1'b1, 1'b0, 1'b0, 8'h68, 8'h60, 8'h50, 8'h40, 8'h30, 1'b1, 1'b0, 1'b1, "ovf_wrap");
    cv(1'b0, 8'h69, 1'b1, 1'b0, 1'b0, 8'h69, 8'h61, 8'h51, 8'h41, 8'h31, 1'b1, 1'b0, 1'b1, "ovf_second");
    blanks(1'b1, 1'b1, "ovf_sticky");

    cv(1'b0, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "vs_dv_rise");
    cv(1'b0, 8'hAB, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "vs_dv_drop");
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    pv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int c = 0; c < 8; c++)
      if (c == 2) cv(1'b0, 8'h72, 1'b1, 1'b0, 1'b0, 8'h72, fill(8'h72), fill(8'h72), fill(8'h72), fill(8'h72),
                     1'b1, 1'b0, 1'b0, "new_frame_top");
      else pv(1'b0, 8'(112 + c), 1'b1, 1'b0, 1'b0);
    blanks(1'b1, 1'b0, "new_frame_end");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      if (vecs[i].chk) checkOutput(vecs[i]);
    end

    // One-pixel line: the end pulse must arrive within a bounded number of cycles.
    begin
      vec_t x;
      bit   seen;
      x.rst = 1'b0; x.pix = 8'h80; x.dv = 1'b1; x.hs = 1'b0; x.vs = 1'b0; x.chk = 1'b0;
      x.ev = '0; x.edv = 1'b0; x.ele = 1'b0; x.eovf = 1'b0; x.tag = "short_line";
      applyStimulus(x);
      x.dv = 1'b0; x.hs = 1'b1; x.pix = 8'h00;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
        applyStimulus(x);
        if (line_end_o) seen = 1'b1;
      end
      checks++;
      if (!seen || dv_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL le_wait: seen=%0b dv_o=%0b, want seen=1 dv_o=0", seen, dv_o);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_line_window.md
Name: conv_line_window

Overview:
- Feeds the 5x5 convolution stage.
- Buffers the last four video lines in block RAM and presents five vertically aligned pixels (current line plus four previous lines) on every active cycle.
- Forwards dv/hs/vs, delayed to match the vertical pixel column.
- Sits between the HDMI RX pixel stream and the convolution block's five row inputs.

Parameters:
- COLORDEPTH, 8, bits per pixel sample.
- SCREENWIDTH, 1600, maximum active pixels per line; sets delay-line depth.
- M_DEPTH, 5, window height. Fixed at 5 because the ports are explicit.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- pix_i  in  COLORDEPTH  incoming pixel, valid when dv_i=1
- dv_i  in  1  data valid (active video)
- hs_i  in  1  horizontal sync
- vs_i  in  1  vertical sync/blank interval, active-high
- vect_o_0  out  COLORDEPTH  current-line pixel
- vect_o_1  out  COLORDEPTH  same column, 1 line earlier
- vect_o_2  out  COLORDEPTH  same column, 2 lines earlier
- vect_o_3  out  COLORDEPTH  same column, 3 lines earlier
- vect_o_4  out  COLORDEPTH  same column, 4 lines earlier
- dv_o  out  1  dv_i delayed to align with vect_o_*
- hs_o  out  1  hs_i delayed equally
- vs_o  out  1  vs_i delayed equally
- line_end_o  out  1  one-cycle pulse on the cycle after the last dv_o=1 of a line
- ovf_o  out  1  sticky: a line exceeded SCREENWIDTH pixels

Behaviour:
- Reset: rst is synchronous, active-high; clock clk. All outputs are 0; col and row_cnt are 0. RAM contents are not cleared; the zero-fill rule masks stale data.
- Accept condition: acc = dv_i & ~vs_i. Pixels with dv_i=1 during vs_i=1 are dropped, and dv_o=0 for them.
- Column pointer col, width clog2(SCREENWIDTH):
  - Increments on each acc.
  - Clears on the first cycle with dv_i=0 after dv_i=1 (line end).
  - Holds during dv_i gaps inside a line only if hs_i has not toggled. A gap is a stall; there is no line end while dv_i stays low within active video.
  - col = SCREENWIDTH-1 with another acc: col wraps to 0 and ovf_o sets. ovf_o clears when vs_i=1.
- Delay lines: four RAMs L1..L4, each SCREENWIDTH x COLORDEPTH, read-before-write at address col.
  - On acc, L1 writes pix_i and L(k+1) writes the read-data of Lk.
  - Read-data of Lk is the pixel from k lines earlier at the same column.
- Latency: exactly 1 clk from pix_i to vect_o_*.
  - vect_o_0 is pix_i registered.
  - vect_o_k is the Lk registered read, with no extra register.
  - dv_o, hs_o, vs_o are 1-stage delays.
- Line counter row_cnt (0..4, saturating):
  - Increments at each line end when row_cnt<4.
  - Clears while vs_i=1.
  - Output k is forced to 0 when k > row_cnt (top-border zero fill).
- When dv_o=0, all vect_o_* are 0.
- line_end_o = dv_o & ~dv_i_delayed_next. It is registered so it asserts on the cycle dv_o first falls.
- Simultaneous vs_i rise and dv_i=1: vs wins; no write; row_cnt clears.
- Reset mid-frame: row_cnt=0 masks old RAM content for the next four lines.
- Writes never occur while rst=1.

Optional Feature:
- Macro: CONV_LINE_WINDOW_REPLICATE_EN.
- Defined: rows k > row_cnt output vect_o_{row_cnt} instead of 0 (top-edge replication).
  - Example: on line 1 of a frame, vect_o_2..4 equal vect_o_1.
- Undefined: zero fill as above. Ports and latency are identical in both builds.

Decomposition:
- Shared package conv_pkg: COLORDEPTH, SCREENWIDTH, M_DEPTH defaults; COL_W = clog2(SCREENWIDTH).
  - The convolution block uses the same constants.
- One sub-module lb_ram: single-port, read-before-write, 1-cycle registered read, depth SCREENWIDTH, width COLORDEPTH, write enable we.
  - Instantiated M_DEPTH-1 times in a generate loop.

Test Plan:
1. Reset behaviour: assert rst 3 cycles during streaming -> all outputs 0 and ovf_o=0 on the cycle after the rst edge and during rst.
2. Window alignment:
   - Setup: SCREENWIDTH=8; 5 lines with pixel = 16*row+col.
   - Stimulus: row 4, col 3 input.
   - Response, 1 cycle later: vect_o_0..4 = 0x43,0x33,0x23,0x13,0x03, dv_o=1.
3. Top border:
   - Stimulus: row 1, col 2.
   - Response: vect_o_0=0x12, vect_o_1=0x02, vect_o_2..4=0.
   - With the macro defined: vect_o_2..4=0x02.
4. Overflow: SCREENWIDTH=8, one line of 10 pixels -> ovf_o=1 from the 9th accepted pixel onward; the 9th pixel is written at col 0. ovf_o clears 1 cycle after vs_i=1.
5. Stall: a 3-cycle dv_i=0 gap with no hs toggle mid-line -> col holds, dv_o=0 for 3 cycles, no line_end_o, and later columns stay correctly aligned.
6. vs_i during dv_i: dv_i=1 with vs_i=1 -> no write, dv_o=0, row_cnt=0; the next frame's line 0 outputs only vect_o_0 nonzero.
